// File: rtl/sfifo_rd_packer.sv
// Read-side packer for the single-clock sfifo: gathers RATIO words into one wide
// valid/ready beat; a flush emits the held partial beat with a lane-keep mask.
module sfifo_rd_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_rempty,
    input  logic [WIDTH-1:0]       fifo_rdata,
    output logic                   fifo_rinc,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep
);

    localparam int CW = $clog2(RATIO) + 1;
    localparam logic [CW-1:0] RATIO_C = CW'(RATIO);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

    // Lanes below n are valid.
    function automatic logic [RATIO-1:0] lane_mask(input logic [CW-1:0] n);
        logic [RATIO-1:0] m;
        m = {RATIO{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            m[i] = (CW'(i) < n);
        end
        return m;
    endfunction

    logic [WIDTH-1:0]       pack_r [RATIO];
    logic [WIDTH-1:0]       pack_s [RATIO];
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_s;
    logic                   rd_pend_r;
    logic                   flush_req_r;
    logic                   flush_req_s;
    logic                   init_r;
    logic                   m_valid_r;
    logic                   m_valid_s;
    logic [WIDTH*RATIO-1:0] m_data_r;
    logic [WIDTH*RATIO-1:0] m_data_s;
    logic [RATIO-1:0]       m_keep_r;
    logic [RATIO-1:0]       m_keep_s;
    logic                   out_free_s;
    logic                   cnt_room_s;
    logic                   rinc_s;

    assign out_free_s = !m_valid_r || m_ready;
    assign cnt_room_s = (cnt_r + {{(CW-1){1'b0}}, rd_pend_r}) < RATIO_C;

    // Read issue: reads are never back-to-back, which keeps the FIFO's late
    // empty flag safe, and stop while a flush is being resolved.
    always_comb begin
        rinc_s = 1'b0;
        if (!init_r && !fifo_rempty && !rd_pend_r && !flush_req_r && cnt_room_s) begin
            rinc_s = 1'b1;
        end else begin
            rinc_s = 1'b0;
        end
    end

    // Capture, full-beat transfer, flush resolution and output drain.
    always_comb begin
        pack_s      = pack_r;
        cnt_s       = cnt_r;
        flush_req_s = flush_req_r | flush;
        m_valid_s   = m_valid_r & ~m_ready;
        m_data_s    = m_data_r;
        m_keep_s    = m_keep_r;
        if (rd_pend_r) begin
            for (int i = 0; i < RATIO; i++) begin
                if (cnt_r == CW'(i)) begin
                    pack_s[i] = fifo_rdata;
                end else begin
                    pack_s[i] = pack_r[i];
                end
            end
            cnt_s = cnt_r + ONE_C;
        end else if (cnt_r == RATIO_C) begin
            if (out_free_s) begin
                for (int i = 0; i < RATIO; i++) begin
                    m_data_s[i*WIDTH +: WIDTH] = pack_r[i];
                    pack_s[i]                  = {WIDTH{1'b0}};
                end
                m_keep_s  = lane_mask(RATIO_C);
                m_valid_s = 1'b1;
                cnt_s     = ZERO_C;
            end else begin
                cnt_s = cnt_r;
            end
        end else if (flush_req_r) begin
            if (cnt_r == ZERO_C) begin
                flush_req_s = flush;
            end else if (out_free_s) begin
                // Lanes beyond cnt are already zero; masking keeps that explicit.
                for (int i = 0; i < RATIO; i++) begin
                    if (CW'(i) < cnt_r) begin
                        m_data_s[i*WIDTH +: WIDTH] = pack_r[i];
                    end else begin
                        m_data_s[i*WIDTH +: WIDTH] = {WIDTH{1'b0}};
                    end
                    pack_s[i] = {WIDTH{1'b0}};
                end
                m_keep_s    = lane_mask(cnt_r);
                m_valid_s   = 1'b1;
                cnt_s       = ZERO_C;
                flush_req_s = flush;
            end else begin
                flush_req_s = 1'b1;
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RATIO; i++) begin
                pack_r[i] <= {WIDTH{1'b0}};
            end
            cnt_r       <= ZERO_C;
            rd_pend_r   <= 1'b0;
            flush_req_r <= 1'b0;
            init_r      <= 1'b1;
            m_valid_r   <= 1'b0;
            m_data_r    <= {(WIDTH*RATIO){1'b0}};
            m_keep_r    <= {RATIO{1'b0}};
        end else begin
            for (int i = 0; i < RATIO; i++) begin
                pack_r[i] <= pack_s[i];
            end
            cnt_r       <= cnt_s;
            rd_pend_r   <= rinc_s;
            flush_req_r <= flush_req_s;
            init_r      <= 1'b0;
            m_valid_r   <= m_valid_s;
            m_data_r    <= m_data_s;
            m_keep_r    <= m_keep_s;
        end
    end

    assign fifo_rinc = rinc_s;
    assign m_valid   = m_valid_r;
    assign m_data    = m_data_r;
    assign m_keep    = m_keep_r;

endmodule

// File: tb/tb_sfifo_rd_packer.sv
// Bench for sfifo_rd_packer: FIFO model, beat-level scoreboard, directed and random traffic.
module tb_sfifo_rd_packer;

    localparam int W = 8;
    localparam int R = 4;

    typedef struct packed {
        logic [W*R-1:0] data;
        logic [R-1:0]   keep;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           fifo_rempty;
    logic [W-1:0]   fifo_rdata;
    logic           fifo_rinc;
    logic           flush;
    logic           m_valid;
    logic           m_ready;
    logic [W*R-1:0] m_data;
    logic [R-1:0]   m_keep;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_valid = -1;

    logic [W-1:0] q[$];
    logic [W-1:0] acc[$];
    beat_t        exp_q[$];
    beat_t        beat_log[$];
    int           beat_cyc[$];
    int           rd_log[$];

    logic           prev_rinc = 1'b0;
    logic           prev_stall = 1'b0;
    logic [W*R-1:0] prev_data = '0;
    logic [R-1:0]   prev_keep = '0;
    logic           rinc_l = 1'b0;
    logic           flush_l = 1'b0;

    sfifo_rd_packer #(.WIDTH(W), .RATIO(R)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_rempty(fifo_rempty),
        .fifo_rdata (fifo_rdata),
        .fifo_rinc  (fifo_rinc),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk(act === exp, name, act, exp);
    endtask

    // Turn the accumulated words into one expected beat, lane 0 oldest.
    task automatic emit_acc();
        beat_t b;
        b = '0;
        foreach (acc[i]) begin
            b.data[i*W +: W] = acc[i];
            b.keep[i]        = 1'b1;
        end
        exp_q.push_back(b);
        acc.delete();
    endtask

    // Output-side checks, sampled mid-cycle.
    task automatic monitor();
        beat_t b;
        if (rst_n) begin
            if (cyc == 0) chk_eq("rinc_cycle0", fifo_rinc, 0);
            if (fifo_rinc) begin
                chk_eq("rinc_back_to_back", prev_rinc, 0);
                rd_log.push_back(cyc);
            end
            if (prev_stall) begin
                chk_eq("hold_valid", m_valid, 1);
                chk_eq("hold_data", m_data, prev_data);
                chk_eq("hold_keep", m_keep, prev_keep);
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_beat", m_data, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk_eq("beat_data", m_data, b.data);
                    chk_eq("beat_keep", m_keep, b.keep);
                end
                beat_log.push_back(beat_t'({m_data, m_keep}));
                beat_cyc.push_back(cyc);
            end
            prev_rinc  = fifo_rinc;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_keep  = m_keep;
        end else begin
            prev_rinc  = 1'b0;
            prev_stall = 1'b0;
        end
    endtask

    // FIFO and word-accounting model applied just after each rising edge.
    task automatic model_edge();
        bit was_empty;
        was_empty = (q.size() == 0);
        if (rst_n) begin
            if (rinc_l) begin
                chk(!was_empty, "read_of_empty", q.size(), 1);
                if (!was_empty) begin
                    fifo_rdata = q.pop_front();
                    acc.push_back(fifo_rdata);
                    if (acc.size() == R) emit_acc();
                end
            end
            if (flush_l && acc.size() > 0) emit_acc();
        end
        fifo_rempty = was_empty;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        rinc_l  = fifo_rinc;
        flush_l = flush;
        @(posedge clk);
        #1;
        model_edge();
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        flush = 1'b0;
        #1;
        chk_eq("rst_valid", m_valid, 0);
        chk_eq("rst_data", m_data, 0);
        chk_eq("rst_keep", m_keep, 0);
        chk_eq("rst_rinc", fifo_rinc, 0);
        q.delete();
        acc.delete();
        exp_q.delete();
        rd_log.delete();
        beat_log.delete();
        beat_cyc.delete();
        first_valid = -1;
    endtask

    task automatic reset_release();
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic push4(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t;
            t = w;
            q.push_back(t[i*8 +: 8]);
        end
    endtask

    task automatic chk_beat(input string name, input int idx, input logic [31:0] d, input logic [3:0] k);
        if (beat_log.size() > idx) begin
            chk_eq(name, beat_log[idx].data, d);
            chk_eq(name, beat_log[idx].keep, k);
        end else begin
            chk(1'b0, name, beat_log.size(), idx + 1);
        end
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        flush       = 1'b0;
        m_ready     = 1'b1;
        fifo_rempty = 1'b1;
        fifo_rdata  = '0;
        @(posedge clk);
        #1;

        // Steady stream timing.
        reset_assert();
        push4(32'h44332211);
        m_ready = 1'b1;
        reset_release();
        run_to(14);
        chk_eq("t1_read_count", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_log.size()) chk_eq("t1_read_cycle", rd_log[i], 1 + 2 * i);
        end
        chk_eq("t1_first_valid", first_valid, 10);
        chk_beat("t1_beat", 0, 32'h44332211, 4'b1111);
        if (beat_cyc.size() > 0) chk_eq("t1_beat_cycle", beat_cyc[0], 10);

        // Back-pressure.
        reset_assert();
        for (int i = 1; i <= 8; i++) q.push_back(8'(i));
        m_ready = 1'b0;
        reset_release();
        run_to(20);
        chk_eq("t2_held_data", m_data, 32'h04030201);
        run_to(30);
        n = 0;
        foreach (rd_log[i]) if (rd_log[i] > 16) n++;
        chk_eq("t2_no_reads_when_full", n, 0);
        chk_eq("t2_read_count", rd_log.size(), 8);
        m_ready = 1'b1;
        run_to(40);
        chk_eq("t2_beat_count", beat_log.size(), 2);
        chk_beat("t2_beat0", 0, 32'h04030201, 4'b1111);
        chk_beat("t2_beat1", 1, 32'h08070605, 4'b1111);
        if (beat_cyc.size() > 1) begin
            chk_eq("t2_beat0_cycle", beat_cyc[0], 30);
            chk_eq("t2_beat1_cycle", beat_cyc[1], 31);
        end

        // Partial beat on flush.
        reset_assert();
        q.push_back(8'hA1);
        q.push_back(8'hA2);
        q.push_back(8'hA3);
        m_ready = 1'b1;
        reset_release();
        run_to(8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        run_to(20);
        chk_eq("t3_read_count", rd_log.size(), 3);
        chk_eq("t3_beat_count", beat_log.size(), 1);
        chk_beat("t3_beat", 0, 32'h00A3A2A1, 4'b0111);

        // Flush with nothing held, then normal reads.
        flush = 1'b1;
        step();
        flush = 1'b0;
        run_to(27);
        chk_eq("t4_no_beat", beat_log.size(), 1);
        push4(32'hB4B3B2B1);
        run_to(50);
        chk_eq("t4_beat_count", beat_log.size(), 2);
        chk_beat("t4_beat", 1, 32'hB4B3B2B1, 4'b1111);

        // FIFO runs dry mid-beat.
        reset_assert();
        q.push_back(8'hE1);
        q.push_back(8'hE2);
        reset_release();
        run_to(12);
        chk_eq("t5_no_partial", beat_log.size(), 0);
        q.push_back(8'hE3);
        q.push_back(8'hE4);
        run_to(40);
        chk_eq("t5_beat_count", beat_log.size(), 1);
        chk_beat("t5_beat", 0, 32'hE4E3E2E1, 4'b1111);

        // Reset mid-pack with a beat stalled on the output.
        reset_assert();
        for (int i = 1; i <= 6; i++) q.push_back(8'hC0 + 8'(i));
        m_ready = 1'b0;
        reset_release();
        run_to(14);
        chk_eq("t6_pre_reset_valid", m_valid, 1);
        reset_assert();
        push4(32'hD4D3D2D1);
        m_ready = 1'b1;
        reset_release();
        run_to(25);
        chk_eq("t6_beat_count", beat_log.size(), 1);
        chk_beat("t6_beat", 0, 32'hD4D3D2D1, 4'b1111);

        // Random traffic against the scoreboard.
        reset_assert();
        reset_release();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom));
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 39) == 0);
            step();
        end
        flush   = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 20000) begin
            step();
            n++;
        end
        chk_eq("drain_fifo", q.size(), 0);
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n = 0;
        while ((exp_q.size() > 0 || m_valid) && n < 200) begin
            step();
            n++;
        end
        chk_eq("drain_beats", exp_q.size(), 0);
        chk_eq("drain_acc", acc.size(), 0);
        chk_eq("drain_valid", m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
